// File: rtl/roi_search_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : roi_search_scheduler
// Description : Frame-level controller for the camera-path ROI search.
//               Sweeps the detector search windows once per frame, arms a
//               validation frame for each accepted candidate, counts edge
//               pixels inside the candidate box, and then either locks the
//               box for display for HOLD_FRAMES frames or rejects it.
//               Optional macro ROI_DUAL_SIDE_EN: both windows sweep and
//               candidates from either side are accepted. Without it, only
//               the left window sweeps and the right window outputs are 0.
// Revision    : 1.0 - initial release
// ============================================================================
module roi_search_scheduler #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int WIN_W       = 300,
  parameter int STEP        = 10,
  parameter int EDGE_THRESH = 12000,
  parameter int HOLD_FRAMES = 60,
  parameter int CW          = 13
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iEN,
  input  logic          iFRAME_START,
  input  logic [CW-1:0] iH_Cont,
  input  logic [CW-1:0] iV_Cont,
  input  logic          iCAND_VALID,
  input  logic          iCAND_SIDE,
  input  logic [CW-1:0] iCAND_X1,
  input  logic [CW-1:0] iCAND_Y1,
  input  logic [CW-1:0] iCAND_X2,
  input  logic [CW-1:0] iCAND_Y2,
  input  logic          iEDGE,
  output logic [CW-1:0] oWIN_L_X1,
  output logic [CW-1:0] oWIN_L_X2,
  output logic [CW-1:0] oWIN_R_X1,
  output logic [CW-1:0] oWIN_R_X2,
  output logic          oSEARCH_EN,
  output logic [CW-1:0] oBOX_X1,
  output logic [CW-1:0] oBOX_Y1,
  output logic [CW-1:0] oBOX_X2,
  output logic [CW-1:0] oBOX_Y2,
  output logic          oBOX_VALID,
  output logic          oREJECT,
  output logic [2:0]    oSTATE
);

  localparam int EW = 15;  // edge counter width
  localparam int HW = 16;  // hold counter width

  localparam logic [CW-1:0] L_X2_RST  = CW'(WIN_W);
  localparam logic [CW-1:0] STEP_C    = CW'(STEP);
  localparam logic [CW-1:0] X_MAX     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_MAX     = CW'(V_TOTAL - 1);
  localparam logic [EW-1:0] CNT_MAX   = '1;
  localparam logic [EW-1:0] THRESH    = EW'(EDGE_THRESH);
  // A zero hold would never expire on a decrement, so it is treated as one frame.
  localparam logic [HW-1:0] HOLD_LOAD = (HOLD_FRAMES == 0) ? HW'(1) : HW'(HOLD_FRAMES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEARCH   = 3'd1,
    ST_ARM      = 3'd2,
    ST_VALIDATE = 3'd3,
    ST_LOCK     = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] win_l_x1, win_l_x2, win_l_x1_n, win_l_x2_n;
  logic [CW-1:0] box_x1, box_y1, box_x2, box_y2;
  logic [CW-1:0] box_x1_n, box_y1_n, box_x2_n, box_y2_n;
  logic [EW-1:0] edge_cnt, edge_cnt_n, cnt_acc;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic          search_en, search_en_n;
  logic          box_valid, box_valid_n;
  logic          reject, reject_n;

  logic [CW-1:0] adv_l_x1, adv_l_x2;
  logic [CW-1:0] cand_x1_c, cand_y1_c, cand_x2_c, cand_y2_c;
  logic          cand_ok, wrap, in_box, at_end;

  assign adv_l_x1 = win_l_x1 + STEP_C;
  assign adv_l_x2 = win_l_x2 + STEP_C;

`ifdef ROI_DUAL_SIDE_EN
  localparam logic [CW-1:0] R_X1_RST = CW'(H_TOTAL);
  localparam logic [CW-1:0] R_X2_RST = CW'(H_TOTAL - WIN_W);

  logic [CW-1:0] win_r_x1, win_r_x2, win_r_x1_n, win_r_x2_n;
  logic [CW-1:0] adv_r_x1, adv_r_x2;

  assign adv_r_x1 = win_r_x1 - STEP_C;
  assign adv_r_x2 = win_r_x2 - STEP_C;
  // Windows have met in the middle: one more step would cross them.
  assign wrap     = ({1'b0, adv_l_x1} + {1'b0, STEP_C}) > {1'b0, adv_r_x2};
  assign cand_ok  = iCAND_VALID && (iCAND_X1 <= iCAND_X2) && (iCAND_Y1 <= iCAND_Y2);
`else
  localparam logic [CW:0] H_TOTAL_W = (CW+1)'(H_TOTAL);

  // Left window would run off the right edge of the line on the next step.
  assign wrap     = ({1'b0, adv_l_x2} + {1'b0, STEP_C}) > H_TOTAL_W;
  assign cand_ok  = iCAND_VALID && !iCAND_SIDE &&
                    (iCAND_X1 <= iCAND_X2) && (iCAND_Y1 <= iCAND_Y2);
`endif

  assign cand_x1_c = (iCAND_X1 > X_MAX) ? X_MAX : iCAND_X1;
  assign cand_x2_c = (iCAND_X2 > X_MAX) ? X_MAX : iCAND_X2;
  assign cand_y1_c = (iCAND_Y1 > Y_MAX) ? Y_MAX : iCAND_Y1;
  assign cand_y2_c = (iCAND_Y2 > Y_MAX) ? Y_MAX : iCAND_Y2;

  assign in_box  = (iH_Cont >= box_x1) && (iH_Cont <= box_x2) &&
                   (iV_Cont >= box_y1) && (iV_Cont <= box_y2);
  assign at_end  = (iH_Cont == box_x2) && (iV_Cont == box_y2);
  // Saturating count that already includes the current pixel, so the decision
  // at the last box pixel sees that pixel too.
  assign cnt_acc = (iEDGE && in_box && (edge_cnt != CNT_MAX)) ? edge_cnt + EW'(1) : edge_cnt;

  // Next-state and next-output decode; every register holds unless changed.
  always_comb begin
    state_n    = state;
    win_l_x1_n = win_l_x1;
    win_l_x2_n = win_l_x2;
`ifdef ROI_DUAL_SIDE_EN
    win_r_x1_n = win_r_x1;
    win_r_x2_n = win_r_x2;
`endif
    box_x1_n   = box_x1;
    box_y1_n   = box_y1;
    box_x2_n   = box_x2;
    box_y2_n   = box_y2;
    edge_cnt_n = edge_cnt;
    hold_cnt_n = hold_cnt;
    reject_n   = 1'b0;

    if (!iEN) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_n = ST_SEARCH;

        ST_SEARCH: begin
          // A candidate takes priority over a same-cycle window advance.
          if (cand_ok) begin
            box_x1_n = cand_x1_c;
            box_y1_n = cand_y1_c;
            box_x2_n = cand_x2_c;
            box_y2_n = cand_y2_c;
            state_n  = ST_ARM;
          end else if (iFRAME_START) begin
            if (wrap) begin
              win_l_x1_n = '0;
              win_l_x2_n = L_X2_RST;
`ifdef ROI_DUAL_SIDE_EN
              win_r_x1_n = R_X1_RST;
              win_r_x2_n = R_X2_RST;
`endif
            end else begin
              win_l_x1_n = adv_l_x1;
              win_l_x2_n = adv_l_x2;
`ifdef ROI_DUAL_SIDE_EN
              win_r_x1_n = adv_r_x1;
              win_r_x2_n = adv_r_x2;
`endif
            end
          end
        end

        ST_ARM: begin
          if (iFRAME_START) begin
            edge_cnt_n = '0;
            state_n    = ST_VALIDATE;
          end
        end

        ST_VALIDATE: begin
          edge_cnt_n = cnt_acc;
          if (at_end) begin
            if (cnt_acc > THRESH) begin
              hold_cnt_n = HOLD_LOAD;
              state_n    = ST_LOCK;
            end else begin
              reject_n = 1'b1;
              state_n  = ST_SEARCH;
            end
          end else if (iFRAME_START) begin
            // The frame ended before the box's last pixel was seen.
            reject_n = 1'b1;
            state_n  = ST_SEARCH;
          end
        end

        ST_LOCK: begin
          if (iFRAME_START) begin
            if (hold_cnt <= HW'(1)) begin
              hold_cnt_n = '0;
              state_n    = ST_SEARCH;
            end else begin
              hold_cnt_n = hold_cnt - HW'(1);
            end
          end
        end

        default: state_n = ST_IDLE;
      endcase
    end

    search_en_n = (state_n == ST_SEARCH);
    box_valid_n = (state_n == ST_LOCK);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= ST_IDLE;
      win_l_x1  <= '0;
      win_l_x2  <= L_X2_RST;
`ifdef ROI_DUAL_SIDE_EN
      win_r_x1  <= R_X1_RST;
      win_r_x2  <= R_X2_RST;
`endif
      box_x1    <= '0;
      box_y1    <= '0;
      box_x2    <= '0;
      box_y2    <= '0;
      edge_cnt  <= '0;
      hold_cnt  <= '0;
      search_en <= 1'b0;
      box_valid <= 1'b0;
      reject    <= 1'b0;
    end else begin
      state     <= state_n;
      win_l_x1  <= win_l_x1_n;
      win_l_x2  <= win_l_x2_n;
`ifdef ROI_DUAL_SIDE_EN
      win_r_x1  <= win_r_x1_n;
      win_r_x2  <= win_r_x2_n;
`endif
      box_x1    <= box_x1_n;
      box_y1    <= box_y1_n;
      box_x2    <= box_x2_n;
      box_y2    <= box_y2_n;
      edge_cnt  <= edge_cnt_n;
      hold_cnt  <= hold_cnt_n;
      search_en <= search_en_n;
      box_valid <= box_valid_n;
      reject    <= reject_n;
    end
  end

  assign oWIN_L_X1  = win_l_x1;
  assign oWIN_L_X2  = win_l_x2;
`ifdef ROI_DUAL_SIDE_EN
  assign oWIN_R_X1  = win_r_x1;
  assign oWIN_R_X2  = win_r_x2;
`else
  assign oWIN_R_X1  = '0;
  assign oWIN_R_X2  = '0;
`endif
  assign oSEARCH_EN = search_en;
  assign oBOX_X1    = box_x1;
  assign oBOX_Y1    = box_y1;
  assign oBOX_X2    = box_x2;
  assign oBOX_Y2    = box_y2;
  assign oBOX_VALID = box_valid;
  assign oREJECT    = reject;
  assign oSTATE     = state;

endmodule
`default_nettype wire

// File: tb/tb_roi_search_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_roi_search_scheduler
// Description : Scoreboard bench for roi_search_scheduler. Stimulus pushes the
//               expected output snapshot and the cycle it must appear in; a
//               monitor pops one entry every time any DUT output changes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_roi_search_scheduler;

  localparam int CW = 13;
`ifdef ROI_DUAL_SIDE_EN
  localparam int WRAP_AT = 25;   // 25th advance: L_X1=250, R_X2=250, 260 > 250
`else
  localparam int WRAP_AT = 50;   // 50th advance: L_X2=800, 810 > 800
`endif

  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, fs = 1'b0;
  logic          cv = 1'b0, cs = 1'b0, edge_px = 1'b0;
  logic [CW-1:0] h = '0, v = '0, cx1 = '0, cy1 = '0, cx2 = '0, cy2 = '0;

  logic [CW-1:0] wl1, wl2, wr1, wr2, bx1, by1, bx2, by2;
  logic          sen, bval, rej;
  logic [2:0]    st;

  roi_search_scheduler dut (
    .iCLK(clk), .iRST_N(rst_n), .iEN(en), .iFRAME_START(fs),
    .iH_Cont(h), .iV_Cont(v),
    .iCAND_VALID(cv), .iCAND_SIDE(cs),
    .iCAND_X1(cx1), .iCAND_Y1(cy1), .iCAND_X2(cx2), .iCAND_Y2(cy2),
    .iEDGE(edge_px),
    .oWIN_L_X1(wl1), .oWIN_L_X2(wl2), .oWIN_R_X1(wr1), .oWIN_R_X2(wr2),
    .oSEARCH_EN(sen),
    .oBOX_X1(bx1), .oBOX_Y1(by1), .oBOX_X2(bx2), .oBOX_Y2(by2),
    .oBOX_VALID(bval), .oREJECT(rej), .oSTATE(st)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0]    st;
    logic          sen, bval, rej;
    logic [CW-1:0] wl1, wl2, wr1, wr2, bx1, by1, bx2, by2;
  } snap_t;

  typedef struct {
    snap_t s;
    int    cyc;
    string tag;
  } exp_t;

  exp_t  q[$];
  snap_t dut_snap;
  assign dut_snap = {st, sen, bval, rej, wl1, wl2, wr1, wr2, bx1, by1, bx2, by2};

  int vectors = 0, miscompares = 0;
  bit mon_on = 1'b0;

  // Expected-output model, updated by hand in the stimulus.
  logic [2:0]    m_st = 3'd0;
  logic          m_sen = 1'b0, m_bval = 1'b0, m_rej = 1'b0;
  logic [CW-1:0] m_wl1, m_wl2, m_wr1, m_wr2, m_bx1, m_by1, m_bx2, m_by2;

  function automatic string fmt(input snap_t s);
    return $sformatf("st=%0d sen=%0b bv=%0b rej=%0b L=[%0d,%0d] R=[%0d,%0d] box=(%0d,%0d)-(%0d,%0d)",
                     s.st, s.sen, s.bval, s.rej, s.wl1, s.wl2, s.wr1, s.wr2,
                     s.bx1, s.by1, s.bx2, s.by2);
  endfunction

  task automatic push(input string tag, input int at_cyc);
    exp_t e;
    e.s   = {m_st, m_sen, m_bval, m_rej, m_wl1, m_wl2, m_wr1, m_wr2,
             m_bx1, m_by1, m_bx2, m_by2};
    e.cyc = at_cyc;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic model_reset();
    m_st = 3'd0; m_sen = 1'b0; m_bval = 1'b0; m_rej = 1'b0;
    m_wl1 = 13'd0; m_wl2 = 13'd300;
`ifdef ROI_DUAL_SIDE_EN
    m_wr1 = 13'd800; m_wr2 = 13'd500;
`else
    m_wr1 = 13'd0;   m_wr2 = 13'd0;
`endif
    m_bx1 = '0; m_by1 = '0; m_bx2 = '0; m_by2 = '0;
  endtask

  task automatic model_advance();
    m_wl1 = m_wl1 + 13'd10;
    m_wl2 = m_wl2 + 13'd10;
`ifdef ROI_DUAL_SIDE_EN
    m_wr1 = m_wr1 - 13'd10;
    m_wr2 = m_wr2 - 13'd10;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cand(input int x1, input int y1, input int x2, input int y2);
    cx1 = CW'(x1); cy1 = CW'(y1); cx2 = CW'(x2); cy2 = CW'(y2);
  endtask

  // Monitor: every change of any output consumes exactly one expectation.
  initial begin : monitor
    snap_t cur, prev;
    exp_t  e;
    bit    first;
    first = 1'b1;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        cur = dut_snap;
        if (first || cur != prev) begin
          first = 1'b0;
          vectors++;
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_change cyc=%0d got %s", cyc, fmt(cur));
          end else begin
            e = q.pop_front();
            if (cur !== e.s || (e.cyc >= 0 && e.cyc != cyc)) begin
              miscompares++;
              $display("FAIL %s cyc=%0d want_cyc=%0d got %s want %s",
                       e.tag, cyc, e.cyc, fmt(cur), fmt(e.s));
            end
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog timeout cyc=%0d want finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    exp_t e;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    push("reset_values", -1);
    mon_on = 1'b1;
    tick();

    // Enable: IDLE -> SEARCH
    en = 1'b1;
    m_st = 3'd1; m_sen = 1'b1;
    push("enable_search", cyc + 1);
    tick(); tick();

    // Window sweep through a wrap and two steps beyond it
    for (int k = 1; k <= WRAP_AT + 2; k++) begin
      fs = 1'b1;
      if (k == WRAP_AT) begin
        m_wl1 = 13'd0; m_wl2 = 13'd300;
`ifdef ROI_DUAL_SIDE_EN
        m_wr1 = 13'd800; m_wr2 = 13'd500;
`endif
        push("win_wrap", cyc + 1);
      end else begin
        model_advance();
        push((k == 3) ? "win_3frames" : "win_adv", cyc + 1);
      end
      tick();
      fs = 1'b0;
      tick();
    end

    // Accept candidate, validate with 12001 edges -> LOCK
    cv = 1'b1; cs = 1'b0; set_cand(100, 50, 199, 149);
    m_st = 3'd2; m_sen = 1'b0;
    m_bx1 = 13'd100; m_by1 = 13'd50; m_bx2 = 13'd199; m_by2 = 13'd149;
    push("cand_accept", cyc + 1);
    tick(); cv = 1'b0; tick();
    fs = 1'b1; m_st = 3'd3;
    push("arm_to_validate", cyc + 1);
    tick();
    fs = 1'b0; h = 13'd100; v = 13'd50; edge_px = 1'b1;
    repeat (12000) tick();
    h = 13'd199; v = 13'd149;
    m_st = 3'd4; m_bval = 1'b1;
    push("lock_12001", cyc + 1);
    tick();
    edge_px = 1'b0; h = '0; v = '0;
    tick();

    // Hold for 60 frames
    for (int k = 1; k <= 60; k++) begin
      fs = 1'b1;
      if (k == 60) begin
        m_st = 3'd1; m_bval = 1'b0; m_sen = 1'b1;
        push("lock_release_60", cyc + 1);
      end
      tick(); fs = 1'b0; tick();
    end

    // Same candidate with exactly 12000 edges -> reject
    cv = 1'b1; set_cand(100, 50, 199, 149);
    m_st = 3'd2; m_sen = 1'b0;
    push("cand_accept2", cyc + 1);
    tick(); cv = 1'b0; tick();
    fs = 1'b1; m_st = 3'd3;
    push("arm_to_validate2", cyc + 1);
    tick();
    fs = 1'b0; h = 13'd100; v = 13'd50; edge_px = 1'b1;
    repeat (11999) tick();
    h = 13'd199; v = 13'd149;
    m_st = 3'd1; m_sen = 1'b1; m_rej = 1'b1;
    push("reject_12000", cyc + 1);
    m_rej = 1'b0;
    push("reject_clear", cyc + 2);
    tick();
    edge_px = 1'b0; h = '0; v = '0;
    tick(); tick();

    // Inverted X candidate is ignored
    cv = 1'b1; set_cand(300, 50, 200, 149);
    tick(); cv = 1'b0; tick(); tick();

    // Clamping of out-of-range corners
    cv = 1'b1; set_cand(100, 50, 900, 600);
    m_st = 3'd2; m_sen = 1'b0;
    m_bx1 = 13'd100; m_by1 = 13'd50; m_bx2 = 13'd799; m_by2 = 13'd524;
    push("cand_clamp", cyc + 1);
    tick(); cv = 1'b0; tick();
    fs = 1'b1; m_st = 3'd3;
    push("arm_to_validate3", cyc + 1);
    tick(); fs = 1'b0; tick(); tick();

    // Drop enable in VALIDATE -> IDLE, no reject
    en = 1'b0; m_st = 3'd0; m_sen = 1'b0;
    push("en_drop", cyc + 1);
    tick(); tick(); tick();
    en = 1'b1; m_st = 3'd1; m_sen = 1'b1;
    push("re_enable", cyc + 1);
    tick(); tick();

`ifndef ROI_DUAL_SIDE_EN
    // Right-side candidate ignored in single-side build
    cv = 1'b1; cs = 1'b1; set_cand(10, 20, 30, 40);
    tick(); cv = 1'b0; cs = 1'b0; tick(); tick();
`endif

    // Candidate and frame start together: candidate wins, no advance
    cv = 1'b1; fs = 1'b1; set_cand(10, 20, 30, 40);
    m_st = 3'd2; m_sen = 1'b0;
    m_bx1 = 13'd10; m_by1 = 13'd20; m_bx2 = 13'd30; m_by2 = 13'd40;
    push("cand_vs_frame", cyc + 1);
    tick(); cv = 1'b0; fs = 1'b0; tick();
    fs = 1'b1; m_st = 3'd3;
    push("arm_to_validate4", cyc + 1);
    tick(); fs = 1'b0; tick(); tick(); tick();

    // Frame start before the end pixel -> reject
    fs = 1'b1;
    m_st = 3'd1; m_sen = 1'b1; m_rej = 1'b1;
    push("reject_frame", cyc + 1);
    m_rej = 1'b0;
    push("reject_frame_clear", cyc + 2);
    tick(); fs = 1'b0; tick(); tick();

    // Advance once, then reset mid-operation
    fs = 1'b1; model_advance();
    push("win_adv_pre_reset", cyc + 1);
    tick(); fs = 1'b0; tick();
    rst_n = 1'b0;
    model_reset();
    push("async_reset", cyc);
    tick(); tick();
    rst_n = 1'b1;
    m_st = 3'd1; m_sen = 1'b1;
    push("search_after_reset", cyc + 1);
    tick(); tick(); tick();

    while (q.size() != 0) begin
      e = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s never_seen want_cyc=%0d want %s", e.tag, e.cyc, fmt(e.s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
